imem_loader: RTL

- Writer side of the word-addressed instruction memory: receives a program as a byte stream, packs bytes into 32-bit little-endian words, and drives a synchronous write port into instruction memory.
- Holds the single-cycle core stalled while loading, then releases it.
- Sits between the host/UART byte receiver and the instruction memory write port. The core's fetch path remains the reader.

---
 rtl/imem_pkg.sv | 16 +
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
package imem_pkg;

   localparam int IMEM_DEPTH  = 256;
   localparam int IMEM_ADDR_W = 8;

   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; byte k lands in bits [8k+7:8k].
module byte_packer
   import imem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       byte_en,
   input  logic [7:0] byte_in,
   output instr_t     word,
   output logic       word_full
);

   logic [1:0] idx;
   instr_t     word_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         word_q <= '0;
      end else if (clear) begin
         idx    <= '0;
         word_q <= '0;
      end else if (byte_en) begin
         word_q[{idx, 3'b000} +: 8] <= byte_in;
         idx                        <= idx + 2'd1;
      end
   end

   // The word including the byte being inserted this cycle, so the 4th byte needs no extra cycle.
   always_comb begin
      word                     = word_q;
      word[{idx, 3'b000} +: 8] = byte_in;
   end

   assign word_full = byte_en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory while holding the core stalled.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output instr_t            mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              len_err
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   loader_state_t   state, state_nxt;
   logic [ADDR_W:0] len, word_cnt, word_cnt_inc, len_clamp;
   logic            start_ok, accept, word_full;
   instr_t          packed_word;

   assign start_ok     = start && ((state == IDLE) || (state == DONE));
   assign len_clamp    = (load_len > DEPTH_W) ? DEPTH_W : load_len;
   assign accept       = byte_valid && byte_ready;
   assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);

   // Clearing on start discards any word left half-packed by an earlier abort.
   byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_ok),
      .byte_en   (accept),
      .byte_in   (byte_data),
      .word      (packed_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nxt = (len_clamp == '0) ? DONE : LOAD;
         LOAD:       if (word_full) state_nxt = WRITE;
         WRITE:      state_nxt = (word_cnt_inc == len) ? DONE : LOAD;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      case (state)
         LOAD:    begin byte_ready = 1'b1; cpu_hold = 1'b1; end
         WRITE:   begin mem_we     = 1'b1; cpu_hold = 1'b1; end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Address and data are captured as the word completes and then held until the next word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len       <= '0;
         word_cnt  <= '0;
         len_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (start_ok) begin
            len      <= len_clamp;
            len_err  <= (load_len > DEPTH_W);
            word_cnt <= '0;
         end
         if (word_full) begin
            mem_wdata <= packed_word;
            mem_addr  <= 32'({word_cnt[ADDR_W-1:0], 2'b00});
         end
         if (state == WRITE) word_cnt <= word_cnt_inc;
      end
   end

endmodule
